decode_pipe_stage: RTL and testbench
====================================

Name: decode_pipe_stage

Overview:
- Registered RV32I decode stage with valid/ready handshake on both sides; replaces the purely combinational control decode.
- Adds illegal-instruction detection, an optional custom-0 quantum-op extension, load-use bubble insertion and flush.
- Adds saturating performance counters.
- Sits between fetch (upstream) and execute (downstream).

Parameters:
- XLEN, 32, width of the PC field carried with the instruction.
- ENABLE_QEXT, 1, 1 = opcode 7'b0001011 (custom-0) decodes as a quantum op; 0 = that opcode is illegal.
- CNT_W, 16, width of each performance counter.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  upstream instruction valid.
- in_ready  out  1  stage can accept this cycle.
- in_instr  in  32  instruction word.
- in_pc  in  XLEN  instruction PC.
- flush  in  1  kill the held and incoming instruction.
- out_valid  out  1  decoded bundle valid.
- out_ready  in  1  downstream accepts the bundle.
- out_pc  out  XLEN  registered PC.
- out_rd, out_rs1, out_rs2  out  5 each  register indices.
- out_funct3  out  3  funct3 field.
- out_reg_wen, out_a_sel, out_b_sel, out_mem_read, out_mem_rw, out_brun, out_branch, out_jump, out_q_op, out_illegal  out  1 each  control flags.
- out_wb_sel  out  2  00 = memory, 01 = ALU, 10 = PC+4, 11 = quantum result.
- out_alu_op  out  4  ALU operation code.
- cnt_decoded, cnt_bubbles, cnt_illegal  out  CNT_W each  performance counters.

Behaviour:
- Reset: out_valid = 0; all out_* fields = 0; all counters = 0. in_ready = 1 in the first cycle after reset.
- Decode tables:
  - ALU op codes: ADD 0, SUB 1, AND 2, OR 3, XOR 4, SLL 5, SRL 6, SRA 7, SLT 8, SLTU 9, PASS_B 10, QOP 15.
  - OP: reg_wen = 1, b_sel = 0, wb_sel = 01, ALU op from {funct7, funct3}. funct7 must be 0x00, or 0x20 for SUB/SRA only; any other funct7 is illegal.
  - OP_IMM: b_sel = 1. SLLI requires funct7 = 0x00. SRLI/SRAI require funct7 = 0x00 or 0x20; otherwise illegal.
  - LOAD: mem_read = 1, wb_sel = 00, ADD.
  - STORE: mem_rw = 1, reg_wen = 0, ADD.
  - BRANCH: branch = 1, a_sel = 1, b_sel = 1, SUB. brun = 1 for funct3 110/111. funct3 010/011 are illegal.
  - JAL, JALR: jump = 1, reg_wen = 1, wb_sel = 10. JALR requires funct3 = 000.
  - LUI: PASS_B.
  - AUIPC: a_sel = 1, ADD.
  - custom-0 with ENABLE_QEXT = 1: q_op = 1, reg_wen = 1, wb_sel = 11, alu_op = 15.
- Illegal instructions (unlisted opcode or an illegal field above): all control flags are 0 except out_illegal = 1. out_valid still asserts so downstream can trap.
- Register use:
  - rs1 is used by OP, OP_IMM, LOAD, STORE, BRANCH, JALR and QOP.
  - rs2 is used by OP, STORE, BRANCH and QOP.
- Pipeline:
  - One-entry output register; latency from acceptance to out_valid is 1 cycle.
  - Accept when in_valid && in_ready.
  - Base readiness: in_ready = (!out_valid || out_ready) && !hazard && !flush.
  - The held bundle stays stable while out_valid && !out_ready.
- Load-use hazard:
  - Asserted when out_valid, out_mem_read and out_rd != 0, and in_valid, and the incoming instruction uses rs1 or rs2 equal to out_rd.
  - With hazard && out_ready: the held bundle leaves, in_ready = 0, and next cycle out_valid = 0 (bubble). cnt_bubbles increments once.
  - In the following cycle the comparison is against an empty register, so the instruction is then accepted.
- Flush:
  - Next cycle out_valid = 0; nothing is accepted in the flush cycle.
  - Flush takes priority over hazard and accept. A bubble is not counted in a flush cycle.
- Counters:
  - cnt_decoded increments on each accept.
  - cnt_illegal increments on each accept that decodes illegal.
  - All counters saturate at 2^CNT_W - 1.
- rst mid-operation: state clears in the same rst cycle, and any in-flight bundle is dropped.

Test Plan:
- ADD x3,x1,x2 (0x002081B3) with out_ready = 1 -> next cycle out_valid = 1, alu_op = 0, reg_wen = 1, wb_sel = 01, rd = 3; cnt_decoded = 1.
- LW x5,0(x1) followed by ADD x6,x5,x2 -> LW out; ADD held 1 cycle (in_ready = 0); one bubble cycle with out_valid = 0; ADD out next; cnt_bubbles = 1. Repeat with rd = x0 -> no bubble.
- out_ready = 0 for 3 cycles holding SUB -> bundle stable, in_ready = 0; on release SUB leaves and the next instruction follows 1 cycle later.
- 0x0000000B with ENABLE_QEXT = 1 -> q_op = 1, alu_op = 15, wb_sel = 11. With ENABLE_QEXT = 0 -> illegal = 1, cnt_illegal = 1. Also 0x4000F033 (AND, funct7 = 0x20) -> illegal.
- Flush asserted while a bundle is held and in_valid = 1 -> next cycle out_valid = 0, no accept, counters unchanged.
- CNT_W = 2: decode 5 instructions -> cnt_decoded = 3 (saturated). rst pulse -> all counters 0, out_valid = 0.

Source files
------------

// File: rtl/decode_pipe_stage.sv
// decode_pipe_stage
//   Registered RV32I decode stage between fetch and execute. Decodes the
//   incoming instruction combinationally and captures the control bundle in
//   a one-entry output register. Adds illegal-instruction detection, an
//   optional custom-0 quantum-op decode, load-use bubble insertion, flush
//   and saturating performance counters.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   in_valid/in_ready upstream handshake; in_instr, in_pc the instruction
//   flush             drops the held bundle and blocks acceptance this cycle
//   out_valid/out_ready downstream handshake
//   out_pc, out_rd, out_rs1, out_rs2, out_funct3   registered fields
//   out_reg_wen .. out_illegal, out_wb_sel, out_alu_op  control bundle
//   cnt_decoded, cnt_bubbles, cnt_illegal          saturating counters
module decode_pipe_stage #(
  parameter int XLEN        = 32,
  parameter bit ENABLE_QEXT = 1'b1,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [XLEN-1:0]  in_pc,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_pc,
  output logic [4:0]       out_rd,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rs2,
  output logic [2:0]       out_funct3,
  output logic             out_reg_wen,
  output logic             out_a_sel,
  output logic             out_b_sel,
  output logic             out_mem_read,
  output logic             out_mem_rw,
  output logic             out_brun,
  output logic             out_branch,
  output logic             out_jump,
  output logic             out_q_op,
  output logic             out_illegal,
  output logic [1:0]       out_wb_sel,
  output logic [3:0]       out_alu_op,
  output logic [CNT_W-1:0] cnt_decoded,
  output logic [CNT_W-1:0] cnt_bubbles,
  output logic [CNT_W-1:0] cnt_illegal
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_CUST0  = 7'b0001011;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLL  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_SLT  = 4'd8;
  localparam logic [3:0] ALU_SLTU = 4'd9;
  localparam logic [3:0] ALU_PASS = 4'd10;
  localparam logic [3:0] ALU_QOP  = 4'd15;

  localparam logic [6:0] F7_ZERO = 7'h00;
  localparam logic [6:0] F7_ALT  = 7'h20;
  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  typedef struct packed {
    logic       reg_wen;
    logic       a_sel;
    logic       b_sel;
    logic       mem_read;
    logic       mem_rw;
    logic       brun;
    logic       branch;
    logic       jump;
    logic       q_op;
    logic       illegal;
    logic [1:0] wb_sel;
    logic [3:0] alu_op;
  } ctrl_t;

  ctrl_t            dec, ctl_q;
  logic             legal, use_rs1, use_rs2;
  logic             hazard, accept, bubble;
  logic [XLEN-1:0]  pc_q;
  logic [4:0]       rd_q, rs1_q, rs2_q;
  logic [2:0]       f3_q;

  logic [6:0] opc, f7;
  logic [2:0] f3;
  logic [4:0] rs1, rs2;
  assign opc = in_instr[6:0];
  assign f3  = in_instr[14:12];
  assign f7  = in_instr[31:25];
  assign rs1 = in_instr[19:15];
  assign rs2 = in_instr[24:20];

  // Register-register / immediate ALU op selected by funct3 alone; the
  // funct7 alternates (SUB, SRA) are patched in by the caller.
  function automatic logic [3:0] f3_alu(input logic [2:0] f);
    case (f)
      3'b000:  f3_alu = ALU_ADD;
      3'b001:  f3_alu = ALU_SLL;
      3'b010:  f3_alu = ALU_SLT;
      3'b011:  f3_alu = ALU_SLTU;
      3'b100:  f3_alu = ALU_XOR;
      3'b101:  f3_alu = ALU_SRL;
      3'b110:  f3_alu = ALU_OR;
      default: f3_alu = ALU_AND;
    endcase
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    sat_inc = (&c) ? c : c + CNT_ONE;
  endfunction

  // Combinational decode. Register-use flags follow the opcode only, so an
  // instruction with a bad field still stalls behind a load like its legal
  // sibling would.
  always_comb begin
    dec     = '0;
    legal   = 1'b0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    case (opc)
      OPC_OP: begin
        use_rs1        = 1'b1;
        use_rs2        = 1'b1;
        dec.reg_wen    = 1'b1;
        dec.wb_sel     = 2'b01;
        dec.alu_op     = f3_alu(f3);
        legal          = (f7 == F7_ZERO) ||
                         ((f7 == F7_ALT) && (f3 == 3'b000 || f3 == 3'b101));
        if (f7 == F7_ALT && f3 == 3'b000) dec.alu_op = ALU_SUB;
        if (f7 == F7_ALT && f3 == 3'b101) dec.alu_op = ALU_SRA;
      end
      OPC_OP_IMM: begin
        use_rs1        = 1'b1;
        dec.reg_wen    = 1'b1;
        dec.b_sel      = 1'b1;
        dec.wb_sel     = 2'b01;
        dec.alu_op     = f3_alu(f3);
        legal          = 1'b1;
        // Only the shift-immediates carry funct7 semantics.
        if (f3 == 3'b001) legal = (f7 == F7_ZERO);
        if (f3 == 3'b101) begin
          legal = (f7 == F7_ZERO) || (f7 == F7_ALT);
          if (f7 == F7_ALT) dec.alu_op = ALU_SRA;
        end
      end
      OPC_LOAD: begin
        use_rs1        = 1'b1;
        dec.reg_wen    = 1'b1;
        dec.b_sel      = 1'b1;
        dec.mem_read   = 1'b1;
        dec.wb_sel     = 2'b00;
        dec.alu_op     = ALU_ADD;
        legal          = 1'b1;
      end
      OPC_STORE: begin
        use_rs1        = 1'b1;
        use_rs2        = 1'b1;
        dec.b_sel      = 1'b1;
        dec.mem_rw     = 1'b1;
        dec.alu_op     = ALU_ADD;
        legal          = 1'b1;
      end
      OPC_BRANCH: begin
        use_rs1        = 1'b1;
        use_rs2        = 1'b1;
        dec.branch     = 1'b1;
        dec.a_sel      = 1'b1;
        dec.b_sel      = 1'b1;
        dec.brun       = f3[2] & f3[1];
        dec.alu_op     = ALU_SUB;
        legal          = !(f3 == 3'b010 || f3 == 3'b011);
      end
      OPC_JAL: begin
        dec.jump       = 1'b1;
        dec.reg_wen    = 1'b1;
        dec.a_sel      = 1'b1;
        dec.b_sel      = 1'b1;
        dec.wb_sel     = 2'b10;
        dec.alu_op     = ALU_ADD;
        legal          = 1'b1;
      end
      OPC_JALR: begin
        use_rs1        = 1'b1;
        dec.jump       = 1'b1;
        dec.reg_wen    = 1'b1;
        dec.b_sel      = 1'b1;
        dec.wb_sel     = 2'b10;
        dec.alu_op     = ALU_ADD;
        legal          = (f3 == 3'b000);
      end
      OPC_LUI: begin
        dec.reg_wen    = 1'b1;
        dec.b_sel      = 1'b1;
        dec.wb_sel     = 2'b01;
        dec.alu_op     = ALU_PASS;
        legal          = 1'b1;
      end
      OPC_AUIPC: begin
        dec.reg_wen    = 1'b1;
        dec.a_sel      = 1'b1;
        dec.b_sel      = 1'b1;
        dec.wb_sel     = 2'b01;
        dec.alu_op     = ALU_ADD;
        legal          = 1'b1;
      end
      OPC_CUST0: begin
        if (ENABLE_QEXT) begin
          use_rs1      = 1'b1;
          use_rs2      = 1'b1;
          dec.q_op     = 1'b1;
          dec.reg_wen  = 1'b1;
          dec.wb_sel   = 2'b11;
          dec.alu_op   = ALU_QOP;
          legal        = 1'b1;
        end
      end
      default: legal = 1'b0;
    endcase
    // Illegal instructions still flow downstream, but with no side effects.
    if (!legal) begin
      dec         = '0;
      dec.illegal = 1'b1;
    end
  end

  // Load-use: the held bundle is a load whose result the incoming
  // instruction needs; it cannot be forwarded in time.
  assign hazard = out_valid && ctl_q.mem_read && (rd_q != 5'd0) && in_valid &&
                  ((use_rs1 && rs1 == rd_q) || (use_rs2 && rs2 == rd_q));

  assign in_ready = (!out_valid || out_ready) && !hazard && !flush;
  assign accept   = in_valid && in_ready;
  assign bubble   = hazard && out_ready && !flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid   <= 1'b0;
      ctl_q       <= '0;
      pc_q        <= '0;
      rd_q        <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      f3_q        <= '0;
      cnt_decoded <= '0;
      cnt_bubbles <= '0;
      cnt_illegal <= '0;
    end else begin
      if (flush) begin
        out_valid <= 1'b0;
      end else if (accept) begin
        out_valid   <= 1'b1;
        ctl_q       <= dec;
        pc_q        <= in_pc;
        rd_q        <= in_instr[11:7];
        rs1_q       <= rs1;
        rs2_q       <= rs2;
        f3_q        <= f3;
        cnt_decoded <= sat_inc(cnt_decoded);
        if (dec.illegal) cnt_illegal <= sat_inc(cnt_illegal);
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (bubble) cnt_bubbles <= sat_inc(cnt_bubbles);
    end
  end

  assign out_pc       = pc_q;
  assign out_rd       = rd_q;
  assign out_rs1      = rs1_q;
  assign out_rs2      = rs2_q;
  assign out_funct3   = f3_q;
  assign out_reg_wen  = ctl_q.reg_wen;
  assign out_a_sel    = ctl_q.a_sel;
  assign out_b_sel    = ctl_q.b_sel;
  assign out_mem_read = ctl_q.mem_read;
  assign out_mem_rw   = ctl_q.mem_rw;
  assign out_brun     = ctl_q.brun;
  assign out_branch   = ctl_q.branch;
  assign out_jump     = ctl_q.jump;
  assign out_q_op     = ctl_q.q_op;
  assign out_illegal  = ctl_q.illegal;
  assign out_wb_sel   = ctl_q.wb_sel;
  assign out_alu_op   = ctl_q.alu_op;

endmodule

// File: tb/tb_decode_pipe_stage.sv
// Bench for decode_pipe_stage. Three instances share one stimulus stream:
// [0] default, [1] ENABLE_QEXT=0, [2] CNT_W=2. Each has its own reference
// model; directed scenarios come first, then random traffic.
module tb_decode_pipe_stage;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic reg_wen, a_sel, b_sel, mem_read, mem_rw, brun, branch, jump, q_op, illegal;
    logic [1:0]  wb;
    logic [3:0]  alu;
  } bnd_t;

  typedef struct {
    bit   v;
    bnd_t b;
    int   dec, bub, ill;
  } mdl_t;

  logic        clk = 1'b0;
  logic        rst, in_valid, flush, out_ready;
  logic [31:0] in_instr, in_pc;

  logic        o_valid [3];
  logic        o_ready [3];
  logic [65:0] obs_b   [3];
  logic [15:0] c_dec   [3];
  logic [15:0] c_bub   [3];
  logic [15:0] c_ill   [3];

  mdl_t m [3];
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int CW = (g == 2) ? 2 : 16;
    localparam bit QX = (g != 1);
    logic [CW-1:0] cd, cb, ci;
    logic [31:0] pc;
    logic [4:0]  rd, r1, r2;
    logic [2:0]  f3;
    logic [1:0]  wb;
    logic [3:0]  alu;
    logic rw, as, bs, mr, mw, bu, br, jp, qo, il;
    decode_pipe_stage #(.XLEN(32), .ENABLE_QEXT(QX), .CNT_W(CW)) u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(o_ready[g]),
      .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
      .out_valid(o_valid[g]), .out_ready(out_ready), .out_pc(pc),
      .out_rd(rd), .out_rs1(r1), .out_rs2(r2), .out_funct3(f3),
      .out_reg_wen(rw), .out_a_sel(as), .out_b_sel(bs), .out_mem_read(mr),
      .out_mem_rw(mw), .out_brun(bu), .out_branch(br), .out_jump(jp),
      .out_q_op(qo), .out_illegal(il), .out_wb_sel(wb), .out_alu_op(alu),
      .cnt_decoded(cd), .cnt_bubbles(cb), .cnt_illegal(ci)
    );
    assign obs_b[g] = {pc, rd, r1, r2, f3, rw, as, bs, mr, mw, bu, br, jp, qo, il, wb, alu};
    assign c_dec[g] = 16'(cd);
    assign c_bub[g] = 16'(cb);
    assign c_ill[g] = 16'(ci);
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk(logic [6:0] f7, logic [4:0] r2, logic [4:0] r1,
                                     logic [2:0] f3, logic [4:0] rd, logic [6:0] op);
    return {f7, r2, r1, f3, rd, op};
  endfunction

  // Reference decode, written from the instruction-set tables.
  function automatic bnd_t mdec(logic [31:0] ins, logic [31:0] pc, bit qx);
    bnd_t b;
    bit ok;
    logic [3:0] by_f3 [8];
    logic [6:0] op, f7;
    logic [2:0] f3;
    by_f3 = '{4'd0, 4'd5, 4'd8, 4'd9, 4'd4, 4'd6, 4'd3, 4'd2};
    op = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25];
    b = '0;
    b.pc = pc; b.rd = ins[11:7]; b.rs1 = ins[19:15]; b.rs2 = ins[24:20]; b.f3 = f3;
    ok = 1;
    case (op)
      7'h33: begin
        b.reg_wen = 1; b.wb = 1; b.alu = by_f3[f3];
        if (f7 == 7'h20) begin
          if (f3 == 0) b.alu = 1;
          else if (f3 == 5) b.alu = 7;
          else ok = 0;
        end else if (f7 != 0) ok = 0;
      end
      7'h13: begin
        b.reg_wen = 1; b.b_sel = 1; b.wb = 1; b.alu = by_f3[f3];
        if (f3 == 1 && f7 != 0) ok = 0;
        if (f3 == 5) begin
          if (f7 == 7'h20) b.alu = 7;
          else if (f7 != 0) ok = 0;
        end
      end
      7'h03: begin b.reg_wen = 1; b.b_sel = 1; b.mem_read = 1; b.wb = 0; end
      7'h23: begin b.b_sel = 1; b.mem_rw = 1; end
      7'h63: begin
        b.branch = 1; b.a_sel = 1; b.b_sel = 1; b.alu = 1; b.brun = (f3 >= 6);
        if (f3 == 2 || f3 == 3) ok = 0;
      end
      7'h6F: begin b.jump = 1; b.reg_wen = 1; b.a_sel = 1; b.b_sel = 1; b.wb = 2; end
      7'h67: begin b.jump = 1; b.reg_wen = 1; b.b_sel = 1; b.wb = 2; ok = (f3 == 0); end
      7'h37: begin b.reg_wen = 1; b.b_sel = 1; b.wb = 1; b.alu = 10; end
      7'h17: begin b.reg_wen = 1; b.a_sel = 1; b.b_sel = 1; b.wb = 1; end
      7'h0B: begin
        if (qx) begin b.q_op = 1; b.reg_wen = 1; b.wb = 3; b.alu = 15; end
        else ok = 0;
      end
      default: ok = 0;
    endcase
    if (!ok) begin
      b = '{pc: pc, rd: ins[11:7], rs1: ins[19:15], rs2: ins[24:20], f3: f3, default: '0};
      b.illegal = 1;
    end
    return b;
  endfunction

  function automatic bit uses1(logic [31:0] ins, bit qx);
    logic [6:0] op = ins[6:0];
    return op inside {7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h67} || (qx && op == 7'h0B);
  endfunction

  function automatic bit uses2(logic [31:0] ins, bit qx);
    logic [6:0] op = ins[6:0];
    return op inside {7'h33, 7'h23, 7'h63} || (qx && op == 7'h0B);
  endfunction

  function automatic bit m_hz(mdl_t s, bit qx);
    return s.v && s.b.mem_read && s.b.rd != 0 && in_valid &&
           ((uses1(in_instr, qx) && in_instr[19:15] == s.b.rd) ||
            (uses2(in_instr, qx) && in_instr[24:20] == s.b.rd));
  endfunction

  function automatic bit m_rdy(mdl_t s, bit qx);
    return (!s.v || out_ready) && !m_hz(s, qx) && !flush;
  endfunction

  function automatic int sat(int c, int cmax);
    return (c < cmax) ? c + 1 : c;
  endfunction

  function automatic mdl_t m_step(mdl_t s, bit qx, int cmax);
    mdl_t n = s;
    if (rst) begin
      n.v = 0; n.b = '0; n.dec = 0; n.bub = 0; n.ill = 0;
    end else if (flush) begin
      n.v = 0;
    end else if (in_valid && m_rdy(s, qx)) begin
      n.v = 1;
      n.b = mdec(in_instr, in_pc, qx);
      n.dec = sat(s.dec, cmax);
      if (n.b.illegal) n.ill = sat(s.ill, cmax);
    end else if (out_ready) begin
      n.v = 0;
      if (m_hz(s, qx)) n.bub = sat(s.bub, cmax);
    end
    return n;
  endfunction

  task automatic drive(bit r, bit iv, logic [31:0] ins, logic [31:0] pc, bit fl, bit ordy);
    rst = r; in_valid = iv; in_instr = ins; in_pc = pc; flush = fl; out_ready = ordy;
    #1;
  endtask

  // Check ready against each model, advance one clock, check outputs.
  task automatic tick();
    mdl_t nx [3];
    for (int g = 0; g < 3; g++) begin
      chk($sformatf("in_ready[%0d]", g), o_ready[g], m_rdy(m[g], g != 1));
      nx[g] = m_step(m[g], g != 1, (g == 2) ? 3 : 65535);
    end
    @(posedge clk); #1;
    for (int g = 0; g < 3; g++) begin
      m[g] = nx[g];
      chk($sformatf("out_valid[%0d]", g), o_valid[g], m[g].v);
      if (m[g].v) chk($sformatf("bundle[%0d]", g), obs_b[g], m[g].b);
      chk($sformatf("cnt_decoded[%0d]", g), c_dec[g], m[g].dec);
      chk($sformatf("cnt_bubbles[%0d]", g), c_bub[g], m[g].bub);
      chk($sformatf("cnt_illegal[%0d]", g), c_ill[g], m[g].ill);
    end
  endtask

  function automatic logic [31:0] rnd_instr();
    logic [6:0] ops [12];
    logic [6:0] f7;
    int k;
    ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h0B, 7'h7F, 7'h00};
    k = $urandom_range(0, 99);
    f7 = (k < 50) ? 7'h00 : (k < 85) ? 7'h20 : 7'($urandom);
    return mk(f7, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 3'($urandom),
              5'($urandom_range(0, 3)), ops[$urandom_range(0, 11)]);
  endfunction

  bnd_t ob;
  logic [31:0] lw, add2, lw0, add0, sub7, add8, add3;

  initial begin
    for (int g = 0; g < 3; g++) begin
      m[g].v = 0; m[g].b = '0; m[g].dec = 0; m[g].bub = 0; m[g].ill = 0;
    end
    rst = 1; in_valid = 0; flush = 0; out_ready = 0; in_instr = 0; in_pc = 0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state
    drive(0, 0, 0, 0, 0, 1);
    chk("rst_valid", o_valid[0], 0);
    chk("rst_ready", o_ready[0], 1);
    chk("rst_bundle", obs_b[0], 0);
    chk("rst_cnt", {c_dec[0], c_bub[0], c_ill[0]}, 0);
    tick();

    // ADD x3,x1,x2
    add3 = 32'h002081B3;
    drive(0, 1, add3, 32'h100, 0, 1); tick();
    ob = bnd_t'(obs_b[0]);
    chk("add_valid", o_valid[0], 1);
    chk("add_alu", ob.alu, 0);
    chk("add_wen", ob.reg_wen, 1);
    chk("add_wb", ob.wb, 2'b01);
    chk("add_rd", ob.rd, 3);
    chk("add_cnt", c_dec[0], 1);

    // Load-use: LW x5 then ADD x6,x5,x2
    lw   = mk(7'h00, 5'd0, 5'd1, 3'd2, 5'd5, 7'h03);
    add2 = mk(7'h00, 5'd2, 5'd5, 3'd0, 5'd6, 7'h33);
    drive(0, 1, lw, 32'h104, 0, 1); tick();
    drive(0, 1, add2, 32'h108, 0, 1);
    chk("hz_ready", o_ready[0], 0);
    tick();
    chk("bubble_valid", o_valid[0], 0);
    chk("bubble_cnt", c_bub[0], 1);
    drive(0, 1, add2, 32'h108, 0, 1);
    chk("post_bubble_ready", o_ready[0], 1);
    tick();
    ob = bnd_t'(obs_b[0]);
    chk("post_bubble_rd", ob.rd, 6);

    // Same with rd = x0: no stall
    lw0  = mk(7'h00, 5'd0, 5'd1, 3'd2, 5'd0, 7'h03);
    add0 = mk(7'h00, 5'd2, 5'd0, 3'd0, 5'd6, 7'h33);
    drive(0, 1, lw0, 32'h10C, 0, 1); tick();
    drive(0, 1, add0, 32'h110, 0, 1);
    chk("x0_ready", o_ready[0], 1);
    tick();
    chk("x0_valid", o_valid[0], 1);
    chk("x0_bub", c_bub[0], 1);

    // Backpressure holding SUB
    sub7 = mk(7'h20, 5'd2, 5'd1, 3'd0, 5'd7, 7'h33);
    add8 = mk(7'h00, 5'd2, 5'd1, 3'd0, 5'd8, 7'h33);
    drive(0, 1, sub7, 32'h114, 0, 1); tick();
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, add8, 32'h118, 0, 0);
      chk("stall_ready", o_ready[0], 0);
      tick();
      ob = bnd_t'(obs_b[0]);
      chk("stall_alu", ob.alu, 1);
      chk("stall_rd", ob.rd, 7);
    end
    drive(0, 1, add8, 32'h118, 0, 1);
    chk("release_ready", o_ready[0], 1);
    tick();
    ob = bnd_t'(obs_b[0]);
    chk("release_rd", ob.rd, 8);

    // custom-0: quantum op vs. illegal
    drive(0, 1, 32'h0000000B, 32'h11C, 0, 1); tick();
    ob = bnd_t'(obs_b[0]);
    chk("qop_flag", ob.q_op, 1);
    chk("qop_alu", ob.alu, 15);
    chk("qop_wb", ob.wb, 2'b11);
    ob = bnd_t'(obs_b[1]);
    chk("noq_illegal", ob.illegal, 1);
    chk("noq_qop", ob.q_op, 0);
    chk("noq_cnt_ill", c_ill[1], 1);
    chk("q_cnt_ill", c_ill[0], 0);

    // AND with funct7=0x20
    drive(0, 1, 32'h4000F033, 32'h120, 0, 1); tick();
    ob = bnd_t'(obs_b[0]);
    chk("and20_illegal", ob.illegal, 1);
    chk("and20_wen", ob.reg_wen, 0);
    chk("and20_cnt_ill", c_ill[0], 1);

    // Flush while holding with an incoming instruction
    drive(0, 0, 0, 0, 0, 1); tick();
    drive(0, 1, add3, 32'h124, 0, 0); tick();
    drive(0, 1, add8, 32'h128, 1, 0);
    chk("flush_ready", o_ready[0], 0);
    tick();
    chk("flush_valid", o_valid[0], 0);
    chk("flush_cnt", c_dec[0], 10);

    // Saturation and mid-run reset
    drive(1, 0, 0, 0, 0, 1); tick();
    chk("rst2_cnt", {c_dec[2], c_bub[2], c_ill[2]}, 0);
    for (int i = 0; i < 5; i++) begin
      drive(0, 1, add3, 32'h200 + 4 * i, 0, 1); tick();
    end
    chk("sat_dec", c_dec[2], 3);
    chk("wide_dec", c_dec[0], 5);
    drive(1, 1, add3, 32'h300, 0, 1); tick();
    chk("rst3_valid", o_valid[2], 0);
    chk("rst3_cnt", c_dec[2], 0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0, rnd_instr(), $urandom,
            $urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
